// File: rtl/uart_sim_monitor_pkg.sv
// ============================================================================
// Module      : uart_sim_monitor_pkg
// Description : Shared types, verdict words and baud helper for the UART
//               simulation monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_sim_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam logic [31:0] PassWord = 32'h5041_5353;
  localparam logic [31:0] FailWord = 32'h4641_494C;

  function automatic int unsigned clks_per_bit(input int unsigned sys_clk_freq,
                                               input int unsigned baud_rate);
    return (sys_clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sim_monitor_rx.sv
// ============================================================================
// Module      : uart_sim_monitor_rx
// Description : 8N1 receiver: line synchroniser, framing FSM, bit timer and
//               LSB-first shift register with registered byte/valid/error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sim_monitor_rx
  import uart_sim_monitor_pkg::*;
#(
  parameter int unsigned ClksPerBit = 33
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       active_i,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  // ClksPerBit must be at least 2 so the half-bit delay is non-zero.
  localparam int unsigned    c_cnt_w    = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(ClksPerBit - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(ClksPerBit / 2 - 1);

  logic [1:0]         r_sync;
  logic               w_rx_s;
  rx_state_e          r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic [7:0]         r_byte;
  logic               r_valid;
  logic               r_ferr;

  assign w_rx_s      = r_sync[1];
  assign rx_byte_o   = r_byte;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_ferr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx_i};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (!active_i) begin
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state <= START;
              r_cnt   <= c_half_last;
            end
          end
          START: begin
            if (r_cnt == '0) begin
              if (w_rx_s) begin
                r_state <= IDLE;
              end else begin
                r_state <= DATA;
                r_idx   <= '0;
                r_cnt   <= c_bit_last;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          DATA: begin
            if (r_cnt == '0) begin
              r_shift <= {w_rx_s, r_shift[7:1]};
              r_idx   <= r_idx + 1'b1;
              r_cnt   <= c_bit_last;
              if (r_idx == 3'd7) r_state <= STOP;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          STOP: begin
            if (r_cnt == '0) begin
              if (w_rx_s) begin
                r_byte  <= r_shift;
                r_valid <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= WAIT_IDLE;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          // A held-low line (break) must release before a new start is hunted.
          WAIT_IDLE: begin
            if (w_rx_s) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_sim_monitor.sv
// ============================================================================
// Module      : uart_sim_monitor
// Description : UART tx-line monitor: decodes bytes, detects "PASS"/"FAIL"
//               end markers and a silent-line timeout, exposes sticky status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sim_monitor
  import uart_sim_monitor_pkg::*;
#(
  parameter int unsigned SysClkFreq    = 30_000_000,
  parameter int unsigned BaudRate      = 921_600,
  parameter int unsigned ClksPerBit    = clks_per_bit(SysClkFreq, BaudRate),
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        active_i,
  input  logic        clear_i,
  input  logic        rx_i,
  output logic [7:0]  rx_byte_o,
  output logic        rx_valid_o,
  output logic        frame_err_o,
  output logic [31:0] byte_count_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic        done_o
);

  logic [31:0] r_window;
  logic [31:0] w_window_next;
  logic [31:0] r_count;
  logic [31:0] r_idle_cnt;
  logic        r_pass;
  logic        r_fail;
  logic        r_timeout;
  logic        w_timeout_hit;

  uart_sim_monitor_rx #(
    .ClksPerBit (ClksPerBit)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .active_i    (active_i),
    .rx_i        (rx_i),
    .rx_byte_o   (rx_byte_o),
    .rx_valid_o  (rx_valid_o),
    .frame_err_o (frame_err_o)
  );

  assign w_window_next = {r_window[23:0], rx_byte_o};
  assign byte_count_o  = r_count;
  assign pass_o        = r_pass;
  assign fail_o        = r_fail;
  assign timeout_o     = r_timeout;
  assign done_o        = r_pass | r_fail | r_timeout;

  generate
    if (TimeoutCycles != 0) begin : g_timeout
      localparam logic [31:0] c_timeout_last = 32'(TimeoutCycles - 1);
      assign w_timeout_hit = (r_idle_cnt == c_timeout_last);
    end else begin : g_no_timeout
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  // Verdicts compare the window as it will be after this byte, so a flag rises
  // one cycle after the rx_valid_o that completes the word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_window   <= '0;
      r_count    <= '0;
      r_idle_cnt <= '0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (clear_i) begin
      r_window   <= '0;
      r_count    <= '0;
      r_idle_cnt <= '0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (rx_valid_o) begin
      r_window   <= w_window_next;
      r_idle_cnt <= '0;
      if (r_count != '1) r_count <= r_count + 32'd1;
      if (!done_o) begin
        if (w_window_next == PassWord)      r_pass <= 1'b1;
        else if (w_window_next == FailWord) r_fail <= 1'b1;
      end
    end else if (!done_o) begin
      r_idle_cnt <= r_idle_cnt + 32'd1;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_sim_monitor.sv
// ============================================================================
// Module      : tb_uart_sim_monitor
// Description : Scoreboard bench for uart_sim_monitor with a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_sim_monitor;

  localparam int CPB = 33;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, active, clear, rx;
  logic [7:0]  rx_byte;
  logic        rx_valid, frame_err, pass, fail, timeout, done;
  logic [31:0] byte_count;

  logic        rst_to_n, rx_to;
  logic [7:0]  rx_byte_to;
  logic        rx_valid_to, frame_err_to, pass_to, fail_to, timeout_to, done_to;
  logic [31:0] byte_count_to;

  uart_sim_monitor dut (
    .clk_i(clk), .rst_ni(rst_n), .active_i(active), .clear_i(clear), .rx_i(rx),
    .rx_byte_o(rx_byte), .rx_valid_o(rx_valid), .frame_err_o(frame_err),
    .byte_count_o(byte_count), .pass_o(pass), .fail_o(fail),
    .timeout_o(timeout), .done_o(done)
  );

  uart_sim_monitor #(.ClksPerBit(CPB), .TimeoutCycles(1000)) dut_to (
    .clk_i(clk), .rst_ni(rst_to_n), .active_i(1'b1), .clear_i(1'b0), .rx_i(rx_to),
    .rx_byte_o(rx_byte_to), .rx_valid_o(rx_valid_to), .frame_err_o(frame_err_to),
    .byte_count_o(byte_count_to), .pass_o(pass_to), .fail_o(fail_to),
    .timeout_o(timeout_to), .done_o(done_to)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: expected frames, received-byte history, verdict flags.
  logic [7:0]  exp_q[$];
  int          fall_q[$];
  logic [7:0]  hist[$];
  bit          m_pass, m_fail, chk_pending;
  int          m_count, ferr_seen, last_valid_to;
  logic [7:0]  mon_eb;
  int          mon_fall;
  logic [31:0] mon_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pass = 0; m_fail = 0; m_count = 0;
    hist.delete();
  endtask

  always @(negedge clk) begin
    if (chk_pending) begin
      chk_pending = 0;
      check("pass_o", {31'd0, pass}, {31'd0, m_pass});
      check("fail_o", {31'd0, fail}, {31'd0, m_fail});
      check("done_o", {31'd0, done}, {31'd0, m_pass | m_fail});
      check("byte_count_o", byte_count, m_count);
    end
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected rx_valid_o: got byte %0h, expected no byte", rx_byte);
      end else begin
        mon_eb   = exp_q.pop_front();
        mon_fall = fall_q.pop_front();
        check("rx_byte_o", {24'd0, rx_byte}, {24'd0, mon_eb});
        check("frame latency", cyc - mon_fall, LAT);
        m_count++;
        hist.push_back(mon_eb);
        if (!(m_pass || m_fail) && hist.size() >= 4) begin
          mon_word = {hist[hist.size()-4], hist[hist.size()-3], hist[hist.size()-2], hist[hist.size()-1]};
          if (mon_word == "PASS") m_pass = 1;
          else if (mon_word == "FAIL") m_fail = 1;
        end
        chk_pending = 1;
      end
    end
    if (frame_err) ferr_seen++;
    if (rx_valid_to) last_valid_to = cyc;
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit expect_it, input bit to_inst);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    @(negedge clk);
    if (expect_it) begin
      exp_q.push_back(b);
      fall_q.push_back(cyc);
    end
    for (int i = 0; i < 10; i++) begin
      if (to_inst) rx_to = bits[i];
      else         rx    = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_str(input logic [31:0] s);
    for (int i = 3; i >= 0; i--) send_frame(s[i*8 +: 8], 1'b1, 1'b1, 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || chk_pending) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  int ferr0, rel;

  initial begin
    rst_n = 0; rst_to_n = 0; active = 1; clear = 0; rx = 1; rx_to = 1;
    chk_pending = 0; ferr_seen = 0; last_valid_to = -1;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset byte_count_o", byte_count, 0);
    check("reset flags", {rx_byte, rx_valid, frame_err, pass, fail, timeout, done}, 0);
    rst_n = 1;
    repeat (5) @(negedge clk);

    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    wait_drain();

    for (int i = 0; i < 12; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_drain();

    send_str("PASS");
    wait_drain();
    check("done after PASS", {31'd0, done}, 1);
    send_str("FAIL");
    wait_drain();
    check("fail_o after PASS", {31'd0, fail}, 0);

    @(negedge clk); clear = 1;
    @(negedge clk); clear = 0;
    model_reset();
    check("clear pass_o", {31'd0, pass}, 0);
    check("clear byte_count_o", byte_count, 0);
    check("clear done_o", {31'd0, done}, 0);

    ferr0 = ferr_seen;
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    repeat (50 * CPB) @(negedge clk);
    rx = 1;
    repeat (2 * CPB) @(negedge clk);
    check("frame_err_o pulses", ferr_seen - ferr0, 1);
    check("byte_count after frame err", byte_count, m_count);
    check("timeout disabled", {31'd0, timeout}, 0);
    send_frame(8'h41, 1'b1, 1'b1, 1'b0);
    wait_drain();

    ferr0 = ferr_seen;
    @(negedge clk); rx = 0;
    repeat (10) @(negedge clk);
    rx = 1;
    repeat (60) @(negedge clk);
    check("glitch frame_err_o", ferr_seen - ferr0, 0);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
    wait_drain();

    fork
      send_frame(8'hC6, 1'b1, 1'b0, 1'b0);
      begin repeat (5 * CPB) @(negedge clk); active = 0; end
    join
    repeat (5) @(negedge clk);
    active = 1;
    check("abort frame_err_o", ferr_seen - ferr0, 0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    wait_drain();

    send_str("PASS");
    wait_drain();
    fork
      send_frame(8'h9C, 1'b1, 1'b0, 1'b0);
      begin
        repeat (100) @(negedge clk);
        rst_n = 0;
        #1;
        check("async reset byte_count_o", byte_count, 0);
        check("async reset flags", {rx_byte, rx_valid, frame_err, pass, fail, timeout, done}, 0);
      end
    join
    model_reset();
    @(negedge clk); rst_n = 1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    wait_drain();

    @(negedge clk); rst_to_n = 1; rel = cyc;
    while (cyc < rel + 999) @(negedge clk);
    check("timeout_o at 999", {31'd0, timeout_to}, 0);
    @(negedge clk);
    check("timeout_o at 1000", {31'd0, timeout_to}, 1);
    check("done_o on timeout", {31'd0, done_to}, 1);

    @(negedge clk); rst_to_n = 0;
    @(negedge clk); rst_to_n = 1; rel = cyc;
    while (cyc < rel + 682) @(negedge clk);
    send_frame(8'h21, 1'b1, 1'b0, 1'b1);
    check("late byte valid cycle", last_valid_to - rel, 999);
    check("late byte value", {24'd0, rx_byte_to}, 8'h21);
    check("timeout_o averted", {31'd0, timeout_to}, 0);
    check("timeout byte_count_o", byte_count_to, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire
